pip_issue_ctrl: RTL and testbench
=================================

Name: pip_issue_ctrl

Overview:
Program sequencer and result collector at the driving end of the 8-bit pipelined processor.
- Holds a small program of (instr, operand A, operand B) entries loaded over a write port.
- On start, streams one entry per cycle into the processor's instr/data_a/data_b inputs, with operands skewed one cycle behind the instruction to match the processor's decode stage.
- Captures each returning result and emits it tagged with its program index.

Parameters:
DEPTH, 16, number of program entries
AW, 4, address width, equals log2(DEPTH)
RES_LAT, 4, rising edges from the instr output update to a stable processor result

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
ld_we  in  1  program write strobe
ld_addr  in  AW  program write address
ld_instr  in  8  opcode to store
ld_a  in  8  operand A to store
ld_b  in  8  operand B to store
start  in  1  begin a run; sampled in IDLE only
prog_len  in  AW+1  number of entries to run, 0..DEPTH
instr  out  8  to processor instr
data_a  out  8  to processor data_a
data_b  out  8  to processor data_b
result  in  8  from processor result
res_valid  out  1  one-cycle pulse: res_data and res_idx are valid
res_idx  out  AW  program index of the result
res_data  out  8  captured result
busy  out  1  run in progress
done  out  1  one-cycle pulse at run completion

Behaviour:
- Reset (reset=0) forces all outputs to 0 and the state to IDLE, and clears the issue pointer, the issue counter and the tag pipeline.
  - Program memory is not reset.
  - Reset mid-run aborts the run with no done pulse.
- Program memory: DEPTH x 24 bits. A write occurs on an edge where ld_we=1 and the state is IDLE. ld_we while busy is ignored.
- State machine: IDLE -> ISSUE -> DRAIN -> FIN -> IDLE.
  - IDLE: instr, data_a and data_b are 0. On an edge with start=1, latch len = min(prog_len, DEPTH) and set busy=1.
    - If len=0: go to FIN.
    - Otherwise: go to ISSUE, with instr <= mem[0].instr on that same edge (call it S).
  - ISSUE: entry i has instr updated at edge S+i. data_a/data_b for entry i are updated at edge S+i+1 (one-cycle skew register).
    - After entry len-1 has been issued, instr returns to 0 and the state goes to DRAIN.
    - data_a/data_b drive 0 in any cycle that carries no entry's operands.
  - DRAIN: issues nothing. Leave DRAIN when the tag pipeline is empty and the last res_valid has been emitted.
  - FIN: done=1 and busy=0 for exactly one cycle, then IDLE.
  - start outside IDLE is ignored.
- Tag pipeline: a RES_LAT-deep shift register of {valid, idx}, loaded at each issue edge.
  - When the tail is valid: res_data <= result, res_idx <= tail idx, res_valid <= 1.
  - Entry i therefore produces res_valid high for the cycle after edge S+i+RES_LAT+1; for RES_LAT=4 that is edge S+i+5.
  - Results emerge in issue order, one per cycle, back-to-back, with no gaps for contiguous issue.
- Timing for len=N>0:
  - busy rises at edge S.
  - Last res_valid follows edge S+N+RES_LAT.
  - done is high after edge S+N+RES_LAT+1, and busy falls on that same edge.
- len=0: busy high for one cycle, done after edge S+1, no res_valid.
- prog_len > DEPTH is clamped to DEPTH. The issue pointer never wraps within a run.
- Arithmetic is the processor's: 8-bit, modulo 256. This block never modifies data.

Test Plan:
- Load {0: 0x01,5,3}, {1: 0x02,10,4}, {2: 0x07,9,9}; start with prog_len=3 -> res_valid after edges S+5, S+6, S+7 with (idx,data) = (0,8), (1,6), (2,0); done after S+8; busy high S..S+8.
- Load {0: 0x01,0xFF,0x02}, {1: 0x02,0x00,0x01}; run with prog_len=2 -> results 0x01 then 0xFF (wrap-around).
- Operand skew: run with prog_len=1 -> instr=0x01 in the cycle after S and data_a/data_b valid in the cycle after S+1; all three 0 elsewhere.
- prog_len=0 -> done pulse after S+1, no res_valid. prog_len=20 -> exactly 16 results, idx 0..15.
- During a run, assert start and ld_we (addr 0, value 0x02,1,1) -> no restart; entry 0 unchanged on the next run.
- Assert reset=0 asynchronously mid-ISSUE -> all outputs 0 immediately, no done. A subsequent run from IDLE behaves identically to the first test.

Source files
------------

// File: rtl/pip_issue_ctrl.sv
// Program sequencer for the 8-bit pipelined processor: streams stored
// (instr, a, b) entries with a one-cycle operand skew and tags returning results.
module pip_issue_ctrl #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned AW      = 4,
    parameter int unsigned RES_LAT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_instr,
    input  logic [7:0]    ld_a,
    input  logic [7:0]    ld_b,
    input  logic          start,
    input  logic [AW:0]   prog_len,
    output logic [7:0]    instr,
    output logic [7:0]    data_a,
    output logic [7:0]    data_b,
    input  logic [7:0]    result,
    output logic          res_valid,
    output logic [AW-1:0] res_idx,
    output logic [7:0]    res_data,
    output logic          busy,
    output logic          done
);

    localparam int unsigned LW = AW + 1;
    localparam logic [AW:0] DEPTH_L = LW'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

    typedef struct packed {
        logic [7:0] instr;
        logic [7:0] a;
        logic [7:0] b;
    } entry_t;

    typedef struct packed {
        logic          v;
        logic [AW-1:0] idx;
    } tag_t;

    entry_t      mem [DEPTH];
    state_t      state;
    state_t      next_state_c;
    logic [AW:0] len;
    logic [AW:0] ptr;
    tag_t        skew_tag;
    logic [7:0]  skew_a;
    logic [7:0]  skew_b;
    tag_t        pipe [RES_LAT];

    logic [AW:0] len_clamp_c;
    logic        inflight_c;
    logic        issue_c;
    logic [AW:0] issue_ptr_c;
    logic [AW:0] ptr_c;
    logic [AW:0] len_c;
    entry_t      rd_c;
    logic [7:0]  instr_c;
    tag_t        skew_tag_c;
    logic [7:0]  skew_a_c;
    logic [7:0]  skew_b_c;
    logic        busy_c;
    logic        done_c;

    assign len_clamp_c = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;

    // Tags still ahead of the tail; the tail itself is captured on the coming edge.
    always_comb begin
        inflight_c = skew_tag.v;
        for (int k = 0; k < int'(RES_LAT) - 1; k++) begin
            inflight_c = inflight_c | pipe[k].v;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state_c;
        end
    end

    always_comb begin
        next_state_c = state;
        case (state)
            IDLE:    if (start) next_state_c = (len_clamp_c == '0) ? FIN : ISSUE;
            ISSUE:   if (ptr >= len) next_state_c = DRAIN;
            DRAIN:   if (!inflight_c) next_state_c = FIN;
            FIN:     next_state_c = IDLE;
            default: next_state_c = IDLE;
        endcase
    end

    always_comb begin
        issue_c     = 1'b0;
        issue_ptr_c = ptr;
        len_c       = len;
        case (state)
            IDLE: begin
                if (start) begin
                    len_c       = len_clamp_c;
                    issue_ptr_c = '0;
                    issue_c     = (len_clamp_c != '0);
                end
            end
            ISSUE:   issue_c = (ptr < len);
            default: issue_c = 1'b0;
        endcase
        rd_c       = mem[issue_ptr_c[AW-1:0]];
        instr_c    = issue_c ? rd_c.instr : 8'h00;
        skew_a_c   = issue_c ? rd_c.a : 8'h00;
        skew_b_c   = issue_c ? rd_c.b : 8'h00;
        skew_tag_c = {issue_c, issue_ptr_c[AW-1:0]};
        ptr_c      = issue_c ? issue_ptr_c + LW'(1) : ptr;
        busy_c     = (next_state_c != IDLE);
        done_c     = (state == FIN);
    end

    // Issue datapath, operand skew stage and result tag pipeline.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len       <= '0;
            ptr       <= '0;
            instr     <= '0;
            skew_tag  <= '0;
            skew_a    <= '0;
            skew_b    <= '0;
            data_a    <= '0;
            data_b    <= '0;
            for (int k = 0; k < int'(RES_LAT); k++) pipe[k] <= '0;
            res_valid <= 1'b0;
            res_idx   <= '0;
            res_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            len      <= len_c;
            ptr      <= ptr_c;
            instr    <= instr_c;
            skew_tag <= skew_tag_c;
            skew_a   <= skew_a_c;
            skew_b   <= skew_b_c;
            data_a   <= skew_a;
            data_b   <= skew_b;
            pipe[0]  <= skew_tag;
            for (int k = 1; k < int'(RES_LAT); k++) pipe[k] <= pipe[k-1];
            res_valid <= pipe[RES_LAT-1].v;
            if (pipe[RES_LAT-1].v) begin
                res_idx  <= pipe[RES_LAT-1].idx;
                res_data <= result;
            end
            busy <= busy_c;
            done <= done_c;
        end
    end

    // Program memory is deliberately left out of reset; writes only land while idle.
    always_ff @(posedge clk) begin
        if (ld_we && state == IDLE) begin
            mem[ld_addr] <= {ld_instr, ld_a, ld_b};
        end
    end

endmodule

// File: tb/tb_pip_issue_ctrl.sv
// Bench for pip_issue_ctrl: a cycle-offset model of a run plus a small
// processor stand-in that returns results RES_LAT edges after issue.
module tb_pip_issue_ctrl;

    localparam int DEPTH   = 16;
    localparam int RES_LAT = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       ld_we;
    logic [3:0] ld_addr;
    logic [7:0] ld_instr;
    logic [7:0] ld_a;
    logic [7:0] ld_b;
    logic       start;
    logic [4:0] prog_len;
    logic [7:0] instr;
    logic [7:0] data_a;
    logic [7:0] data_b;
    logic [7:0] result = 8'h00;
    logic       res_valid;
    logic [3:0] res_idx;
    logic [7:0] res_data;
    logic       busy;
    logic       done;

    pip_issue_ctrl #(.DEPTH(16), .AW(4), .RES_LAT(4)) dut (
        .clk(clk), .reset(reset), .ld_we(ld_we), .ld_addr(ld_addr),
        .ld_instr(ld_instr), .ld_a(ld_a), .ld_b(ld_b), .start(start),
        .prog_len(prog_len), .instr(instr), .data_a(data_a), .data_b(data_b),
        .result(result), .res_valid(res_valid), .res_idx(res_idx),
        .res_data(res_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;
    bit chk_en = 1'b0;

    function automatic void chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endfunction

    function automatic logic [7:0] alu(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            8'h01:   return a + b;
            8'h02:   return a - b;
            8'h07:   return a ^ b;
            default: return 8'h00;
        endcase
    endfunction

    // Processor stand-in: decode takes instr one cycle ahead of its operands.
    logic [7:0] prev_instr = 8'h00;
    logic [7:0] rp [3] = '{8'h00, 8'h00, 8'h00};
    always @(negedge clk) begin
        result     = rp[2];
        rp[2]      = rp[1];
        rp[1]      = rp[0];
        rp[0]      = alu(prev_instr, data_a, data_b);
        prev_instr = instr;
    end

    // Model: bench copy of the program and the cycle offset t since the start edge.
    logic [7:0] pm_i [DEPTH];
    logic [7:0] pm_a [DEPTH];
    logic [7:0] pm_b [DEPTH];
    bit m_run = 1'b0;
    int m_t, m_n, m_d;
    int m_done_t = -1;
    int m_busy_cnt = 0;
    int res_t_q[$];
    int res_idx_q[$];
    int res_data_q[$];
    int instr_log[32];
    int a_log[32];
    int b_log[32];

    always @(posedge clk) begin
        if (!reset) begin
            m_run = 1'b0;
        end else if (m_run) begin
            if (m_t == m_d) m_run = 1'b0;
            else m_t = m_t + 1;
        end else begin
            if (ld_we) begin
                pm_i[ld_addr] = ld_instr;
                pm_a[ld_addr] = ld_a;
                pm_b[ld_addr] = ld_b;
            end
            if (start) begin
                m_run = 1'b1;
                m_t   = 0;
                m_n   = (int'(prog_len) > DEPTH) ? DEPTH : int'(prog_len);
                m_d   = (m_n == 0) ? 1 : m_n + RES_LAT + 1;
                m_done_t   = -1;
                m_busy_cnt = 0;
                res_t_q.delete();
                res_idx_q.delete();
                res_data_q.delete();
                for (int k = 0; k < 32; k++) begin
                    instr_log[k] = -1;
                    a_log[k]     = -1;
                    b_log[k]     = -1;
                end
            end
        end
    end

    int e_instr, e_a, e_b, e_rv, e_busy, e_done, e_k;
    always @(negedge clk) begin
        if (chk_en) begin
            if (!reset) begin
                chk("rst_instr", int'(instr), 0);
                chk("rst_data_a", int'(data_a), 0);
                chk("rst_data_b", int'(data_b), 0);
                chk("rst_res_valid", int'(res_valid), 0);
                chk("rst_busy", int'(busy), 0);
                chk("rst_done", int'(done), 0);
            end else if (m_run) begin
                e_busy  = (m_t < m_d) ? 1 : 0;
                e_done  = (m_t == m_d) ? 1 : 0;
                e_instr = (m_t < m_n) ? int'(pm_i[4'(m_t)]) : 0;
                e_a     = (m_t >= 1 && m_t <= m_n) ? int'(pm_a[4'(m_t - 1)]) : 0;
                e_b     = (m_t >= 1 && m_t <= m_n) ? int'(pm_b[4'(m_t - 1)]) : 0;
                e_rv    = (m_n > 0 && m_t >= RES_LAT + 1 && m_t <= m_n + RES_LAT) ? 1 : 0;
                chk("busy", int'(busy), e_busy);
                chk("done", int'(done), e_done);
                chk("instr", int'(instr), e_instr);
                chk("data_a", int'(data_a), e_a);
                chk("data_b", int'(data_b), e_b);
                chk("res_valid", int'(res_valid), e_rv);
                if (e_rv != 0) begin
                    e_k = m_t - RES_LAT - 1;
                    chk("res_idx", int'(res_idx), e_k);
                    chk("res_data", int'(res_data),
                        int'(alu(pm_i[4'(e_k)], pm_a[4'(e_k)], pm_b[4'(e_k)])));
                end
                if (res_valid) begin
                    res_t_q.push_back(m_t);
                    res_idx_q.push_back(int'(res_idx));
                    res_data_q.push_back(int'(res_data));
                end
                if (done) m_done_t = m_t;
                if (busy) m_busy_cnt++;
                if (m_t < 32) begin
                    instr_log[m_t] = int'(instr);
                    a_log[m_t]     = int'(data_a);
                    b_log[m_t]     = int'(data_b);
                end
            end else begin
                chk("idle_instr", int'(instr), 0);
                chk("idle_data_a", int'(data_a), 0);
                chk("idle_data_b", int'(data_b), 0);
                chk("idle_res_valid", int'(res_valid), 0);
                chk("idle_busy", int'(busy), 0);
                chk("idle_done", int'(done), 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] addr, input logic [7:0] i, input logic [7:0] a, input logic [7:0] b);
        ld_we = 1'b1; ld_addr = addr; ld_instr = i; ld_a = a; ld_b = b;
        tick();
        ld_we = 1'b0;
    endtask

    task automatic run(input int len);
        prog_len = 5'(len);
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", int'(done === 1'b1), 1);
        tick();
        tick();
    endtask

    // Hand-computed expectations for the three-entry reference program.
    task automatic check_t1(input string tag);
        chk({tag, "_nres"}, res_t_q.size(), 3);
        if (res_t_q.size() == 3) begin
            chk({tag, "_t0"}, res_t_q[0], 5);
            chk({tag, "_t2"}, res_t_q[2], 7);
            chk({tag, "_i1"}, res_idx_q[1], 1);
            chk({tag, "_d0"}, res_data_q[0], 8);
            chk({tag, "_d1"}, res_data_q[1], 6);
            chk({tag, "_d2"}, res_data_q[2], 0);
        end
        chk({tag, "_done_t"}, m_done_t, 8);
        chk({tag, "_busy_cycles"}, m_busy_cnt, 8);
    endtask

    task automatic load_t1();
        load(4'd0, 8'h01, 8'd5, 8'd3);
        load(4'd1, 8'h02, 8'd10, 8'd4);
        load(4'd2, 8'h07, 8'd9, 8'd9);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_instr = '0; ld_a = '0; ld_b = '0;
        start = 1'b0; prog_len = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("por_busy", int'(busy), 0);
        chk("por_res_valid", int'(res_valid), 0);
        tick();
        reset = 1'b1;
        tick();

        load_t1();
        run(3);
        wait_done();
        check_t1("basic");

        load(4'd0, 8'h01, 8'hFF, 8'h02);
        load(4'd1, 8'h02, 8'h00, 8'h01);
        run(2);
        wait_done();
        chk("wrap_nres", res_data_q.size(), 2);
        if (res_data_q.size() == 2) begin
            chk("wrap_d0", res_data_q[0], 1);
            chk("wrap_d1", res_data_q[1], 255);
        end
        chk("wrap_done_t", m_done_t, 7);

        run(1);
        wait_done();
        chk("skew_instr_t0", instr_log[0], 1);
        chk("skew_instr_t1", instr_log[1], 0);
        chk("skew_a_t0", a_log[0], 0);
        chk("skew_a_t1", a_log[1], 255);
        chk("skew_b_t1", b_log[1], 2);
        chk("skew_a_t2", a_log[2], 0);
        chk("skew_nres", res_data_q.size(), 1);
        chk("skew_done_t", m_done_t, 6);

        run(0);
        wait_done();
        chk("zero_done_t", m_done_t, 1);
        chk("zero_nres", res_t_q.size(), 0);
        chk("zero_busy_cycles", m_busy_cnt, 1);

        for (int i = 0; i < 16; i++) begin
            load(4'(i), (i % 3 == 0) ? 8'h01 : ((i % 3 == 1) ? 8'h02 : 8'h07),
                 8'(i * 37), 8'(i * 11 + 3));
        end
        run(20);
        wait_done();
        chk("clamp_nres", res_idx_q.size(), 16);
        if (res_idx_q.size() == 16) begin
            chk("clamp_i0", res_idx_q[0], 0);
            chk("clamp_i15", res_idx_q[15], 15);
            chk("clamp_d1", res_data_q[1], 23);
            chk("clamp_d15", res_data_q[15], 211);
        end
        chk("clamp_done_t", m_done_t, 21);

        load_t1();
        run(3);
        start = 1'b1; ld_we = 1'b1; ld_addr = 4'd0;
        ld_instr = 8'h02; ld_a = 8'd1; ld_b = 8'd1;
        tick();
        start = 1'b0; ld_we = 1'b0;
        wait_done();
        check_t1("ignore_run");
        run(3);
        wait_done();
        check_t1("ignore_rerun");

        run(3);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_instr", int'(instr), 0);
        chk("abort_data_a", int'(data_a), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        tick();
        reset = 1'b1;
        repeat (8) tick();
        chk("abort_no_done", m_done_t, -1);
        run(3);
        wait_done();
        check_t1("after_abort");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
